pixel_stream_feeder: RTL and testbench
======================================

# pixel_stream_feeder

Upstream stage of `generated_model`. It accepts one image as a byte stream over a valid/ready handshake from the UART receive path and buffers the whole frame. It then replays the frame to the model as `input_index`/`input_value`/`input_enable`, one pixel per cycle, and captures the model's valid-flagged `output_result` as a one-cycle classification pulse. It serialises images, so only one frame is in flight at a time.

## Interface
- `DATA_WIDTH`, 8, pixel width in bits.
- `PIXEL_COUNT`, 1024, pixels per image.
- `INDEX_WIDTH`, 10, pixel index width; must satisfy `2**INDEX_WIDTH >= PIXEL_COUNT`.
- `RESULT_WIDTH`, `DATA_WIDTH*4+2`, width of the model result excluding its valid bit.
- `TIMEOUT_CYCLES`, 65535, maximum wait for a model result.
- `clk` in 1: single clock.
- `rst` in 1: reset; synchronous and active-high.
- `in_data` in `DATA_WIDTH`: incoming pixel byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: feeder accepts a byte this cycle.
- `input_index` out `INDEX_WIDTH`: pixel index to the model.
- `input_value` out `DATA_WIDTH`: pixel value to the model.
- `input_enable` out 1: index/value valid this cycle.
- `output_result` in `RESULT_WIDTH+1`: from the model; MSB is the valid bit, low bits are the class.
- `class_out` out `RESULT_WIDTH`: last captured class.
- `class_valid` out 1: one-cycle pulse when `class_out` updates.
- `timeout_err` out 1: sticky flag; set on a result timeout, cleared only by `rst`.
- `busy` out 1: high in STREAM and WAIT_RESULT.

## Operation
- The FSM has three states: FILL, STREAM and WAIT_RESULT. Reset enters FILL.
- **FILL**
  - `in_ready`=1.
  - A byte is accepted when `in_valid & in_ready`. It is written to the buffer at `wr_ptr`, and `wr_ptr` increments.
  - On the byte with `wr_ptr==PIXEL_COUNT-1`: `wr_ptr` returns to 0 and the FSM moves to STREAM.
- **STREAM**
  - `in_ready`=0.
  - `rd_ptr` walks 0..`PIXEL_COUNT-1`, one address per cycle with no gaps.
  - Each read produces a registered `input_value`/`input_index` with `input_enable`=1.
  - After the last address is issued, the FSM moves to WAIT_RESULT. The final pixel is still delivered one cycle later by the read pipeline.
- **WAIT_RESULT**
  - `in_ready`=0.
  - The timeout counter runs from 0.
  - On `output_result[RESULT_WIDTH]`=1: latch the low `RESULT_WIDTH` bits into `class_out`, pulse `class_valid`, clear the counter, and move to FILL.
  - If the counter reaches `TIMEOUT_CYCLES` with no result: set `timeout_err`, leave `class_out` unchanged, do not pulse `class_valid`, and move to FILL.
- A result-valid that arrives in FILL or STREAM is ignored and does not change `class_out`.
- A result-valid and a timeout in the same cycle: the result wins and `timeout_err` is not set.
- Reset asserted mid-frame discards the partial image; no pixels are emitted for it.
- Buffer contents are not cleared by reset. Every frame overwrites all `PIXEL_COUNT` entries before it is read.
- Indices are zero-extended to `INDEX_WIDTH`. `input_index` never exceeds `PIXEL_COUNT-1`.

## Timing
- Reset values: `in_ready`=0 during reset and 1 on the first cycle after. All other outputs are 0: `input_index`, `input_value`, `input_enable`, `class_out`, `class_valid`, `timeout_err` and `busy`.
- Last byte accepted at edge k:
  - STREAM starts at k+1.
  - The buffer has a 1-cycle registered read.
  - `input_enable` is high with index 0 at cycles k+2 .. k+`PIXEL_COUNT`+1, and index i at cycle k+2+i.
  - `input_enable` is low from k+`PIXEL_COUNT`+2.
- Result valid sampled at edge t: `class_valid`=1 and `class_out` updated in cycle t+1. `in_ready`=1 in cycle t+1.
- `class_valid` is exactly one cycle wide.
- Throughput: one byte per cycle in FILL. The model is never stalled during STREAM.

## Structure
- Shared package `ml_fpga_pkg` holds:
  - `DATA_WIDTH`, `PIXEL_COUNT`, `INDEX_WIDTH` and the `RESULT_WIDTH` derivation;
  - the `feeder_state_t` enum (FILL, STREAM, WAIT_RESULT).
- One sub-module: `pixel_frame_buffer`, a simple dual-port RAM (`PIXEL_COUNT` x `DATA_WIDTH`) with a synchronous write port and a registered read port; it must infer block RAM.
- The FSM, pointers, timeout counter and result capture live in the top level.

## Test plan
- **Basic frame.** Stream 1024 bytes with value `i%256`, `in_valid` held high. Require `in_ready` low after byte 1023, then 1024 consecutive `input_enable` cycles with `input_index`=i and `input_value`=`i%256`, no gaps.
- **Result capture.** Model stub returns `output_result`={1'b1, 34'd7} 50 cycles after the last pixel. Require `class_out`=7, one `class_valid` pulse, and `in_ready`=1 the next cycle.
- **Ten frames.** Stream 10 frames back-to-back; stub returns class n for frame n. Require `class_out` sequence 0..9 and exactly 10 `class_valid` pulses.
- **Bursty input.** Toggle `in_valid` randomly (50%) during FILL. Require the emitted pixel order and values to be identical to the basic-frame case.
- **Timeout.** Set `TIMEOUT_CYCLES`=100 and have the stub never respond. Require `timeout_err`=1 at cycle 100 of WAIT_RESULT, no `class_valid`, a return to FILL, and correct streaming of the next frame.
- **Reset mid-fill.** Assert `rst` after 500 bytes, then send a full frame. Require exactly 1024 `input_enable` cycles containing only the new frame's data, and `timeout_err`=0.

Source files
------------

// File: rtl/ml_fpga_pkg.sv
// Shared constants and types for the ml_fpga image path.
// Widths default to the 32x32 8-bit image fed to generated_model.
package ml_fpga_pkg;

    localparam int DATA_WIDTH     = 8;
    localparam int PIXEL_COUNT    = 1024;
    localparam int INDEX_WIDTH    = 10;
    localparam int RESULT_WIDTH   = DATA_WIDTH * 4 + 2;
    localparam int TIMEOUT_CYCLES = 65535;

    typedef enum logic [1:0] {
        FILL,
        STREAM,
        WAIT_RESULT
    } feeder_state_t;

endpackage

// File: rtl/pixel_stream_feeder_if.sv
// Byte stream handshake from the UART receive path into the pixel feeder.
// The master drives data/valid; the slave (feeder) drives ready.
interface pixel_stream_feeder_if #(
    parameter int DATA_WIDTH = ml_fpga_pkg::DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/pixel_frame_buffer.sv
// Simple dual-port frame store: synchronous write, registered read.
// Written so synthesis maps it onto a single block RAM.
module pixel_frame_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array itself is never reset; a reset loop over every entry
    // would block RAM inference, and each frame rewrites all entries anyway.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register reset maps onto the RAM's own output-register reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pixel_stream_feeder.sv
// Buffers one image from the byte stream, replays it to generated_model one
// pixel per cycle, and captures the model's valid-flagged classification.
module pixel_stream_feeder
    import ml_fpga_pkg::*;
#(
    parameter int DATA_WIDTH     = ml_fpga_pkg::DATA_WIDTH,
    parameter int PIXEL_COUNT    = ml_fpga_pkg::PIXEL_COUNT,
    parameter int INDEX_WIDTH    = ml_fpga_pkg::INDEX_WIDTH,
    parameter int RESULT_WIDTH   = DATA_WIDTH * 4 + 2,
    parameter int TIMEOUT_CYCLES = ml_fpga_pkg::TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst,
    pixel_stream_feeder_if.slave    byte_in,
    output logic [INDEX_WIDTH-1:0]  input_index,
    output logic [DATA_WIDTH-1:0]   input_value,
    output logic                    input_enable,
    input  logic [RESULT_WIDTH:0]   output_result,
    output logic [RESULT_WIDTH-1:0] class_out,
    output logic                    class_valid,
    output logic                    timeout_err,
    output logic                    busy
);

    localparam int TO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INDEX_WIDTH-1:0] LAST_PIXEL = INDEX_WIDTH'(PIXEL_COUNT - 1);
    // WAIT_RESULT lasts at most TIMEOUT_CYCLES cycles, counted 0..TIMEOUT_CYCLES-1.
    localparam logic [TO_WIDTH-1:0]    TO_LAST    = TO_WIDTH'(TIMEOUT_CYCLES - 1);

    feeder_state_t          state_q, state_d;
    logic [INDEX_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [TO_WIDTH-1:0]    to_cnt_q;
    logic                   accept, in_stream, in_wait;
    logic                   result_hit, timeout_hit;

    assign accept      = byte_in.in_valid & byte_in.in_ready;
    assign in_stream   = (state_q == STREAM);
    assign in_wait     = (state_q == WAIT_RESULT);
    assign result_hit  = in_wait & output_result[RESULT_WIDTH];
    // A result arriving on the last allowed cycle beats the timeout.
    assign timeout_hit = in_wait & ~output_result[RESULT_WIDTH] & (to_cnt_q == TO_LAST);
    assign busy        = (state_q != FILL);

    pixel_frame_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (PIXEL_COUNT),
        .ADDR_WIDTH (INDEX_WIDTH)
    ) u_frame_buffer (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_addr (wr_ptr_q),
        .wr_data (byte_in.in_data),
        .rd_en   (in_stream),
        .rd_addr (rd_ptr_q),
        .rd_data (input_value)
    );

    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL:        if (accept && wr_ptr_q == LAST_PIXEL) state_d = STREAM;
            STREAM:      if (rd_ptr_q == LAST_PIXEL)           state_d = WAIT_RESULT;
            WAIT_RESULT: if (result_hit || timeout_hit)        state_d = FILL;
            default:     state_d = FILL;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only, so every
    // right-hand side below sees pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= FILL;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            to_cnt_q         <= '0;
            byte_in.in_ready <= 1'b0;
            input_index      <= '0;
            input_enable     <= 1'b0;
            class_out        <= '0;
            class_valid      <= 1'b0;
            timeout_err      <= 1'b0;
        end else begin
            state_q          <= state_d;
            byte_in.in_ready <= (state_d == FILL);

            if (accept) begin
                wr_ptr_q <= (wr_ptr_q == LAST_PIXEL) ? '0 : wr_ptr_q + INDEX_WIDTH'(1);
            end

            // Index is registered alongside the RAM read so both land together.
            if (in_stream) begin
                rd_ptr_q    <= (rd_ptr_q == LAST_PIXEL) ? '0 : rd_ptr_q + INDEX_WIDTH'(1);
                input_index <= rd_ptr_q;
            end
            input_enable <= in_stream;

            to_cnt_q <= (in_wait && state_d == WAIT_RESULT) ? to_cnt_q + TO_WIDTH'(1) : '0;

            class_valid <= result_hit;
            if (result_hit) begin
                class_out <= output_result[RESULT_WIDTH-1:0];
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_stream_feeder.sv
// Self-checking bench for pixel_stream_feeder: a frame-level pixel model with
// a per-cycle compare process, plus directed result/timeout/reset scenarios.
module tb_pixel_stream_feeder;

    localparam int DW      = 8;
    localparam int NPIX    = 1024;
    localparam int IW      = 10;
    localparam int RW      = DW * 4 + 2;
    localparam int TB_TOUT = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] input_index;
    logic [DW-1:0] input_value;
    logic          input_enable;
    logic [RW:0]   output_result;
    logic [RW-1:0] class_out;
    logic          class_valid;
    logic          timeout_err;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int en_count = 0;
    int pulse_count = 0;
    bit mon_on = 1'b0;

    // Pixel model: flat queue of expected bytes and the edge count at which
    // each frame's first pixel must appear.
    logic [DW-1:0] exp_pix[$];
    int            exp_start[$];

    pixel_stream_feeder_if #(.DATA_WIDTH(DW)) byte_if ();

    pixel_stream_feeder #(
        .DATA_WIDTH     (DW),
        .PIXEL_COUNT    (NPIX),
        .INDEX_WIDTH    (IW),
        .RESULT_WIDTH   (RW),
        .TIMEOUT_CYCLES (TB_TOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .byte_in       (byte_if),
        .input_index   (input_index),
        .input_value   (input_value),
        .input_enable  (input_enable),
        .output_result (output_result),
        .class_out     (class_out),
        .class_valid   (class_valid),
        .timeout_err   (timeout_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic logic [DW-1:0] pix_val(input int pat, input int i);
        return (pat == 0) ? DW'(i) : DW'(i * 3 + pat * 17);
    endfunction

    // Per-cycle compare of the model pixel stream against the DUT.
    always @(negedge clk) begin
        bit exp_en;
        int idx;
        exp_en = 1'b0;
        idx = 0;
        if (mon_on) begin
            if (exp_start.size() > 0 && edge_cnt >= exp_start[0]) begin
                exp_en = 1'b1;
                idx = edge_cnt - exp_start[0];
            end
            check("input_enable", 64'(input_enable), 64'(exp_en));
            if (exp_en) begin
                check("input_index", 64'(input_index), 64'(idx));
                check("input_value", 64'(input_value), 64'(exp_pix[idx]));
                if (idx == NPIX - 1) begin
                    void'(exp_start.pop_front());
                    for (int k = 0; k < NPIX; k++) void'(exp_pix.pop_front());
                end
            end
            if (input_enable === 1'b1) en_count++;
            if (class_valid === 1'b1) pulse_count++;
        end
    end

    // Called and returning on a negedge; e is the edge count of the last accepted byte.
    task automatic send_frame(input int pat, input int n, input bit bursty, output int e);
        logic [DW-1:0] tmp[$];
        int guard;
        for (int i = 0; i < n; i++) begin
            if (bursty) begin
                while ($urandom_range(1) == 0) begin
                    byte_if.in_valid = 1'b0;
                    @(negedge clk);
                end
            end
            byte_if.in_data  = pix_val(pat, i);
            byte_if.in_valid = 1'b1;
            guard = 0;
            while (byte_if.in_ready !== 1'b1) begin
                @(negedge clk);
                guard++;
                if (guard > 4000) begin
                    $display("FAIL in_ready_wait: got 0 expected 1 within 4000 cycles");
                    $fatal(1, "in_ready never asserted");
                end
            end
            @(negedge clk);
            tmp.push_back(pix_val(pat, i));
        end
        byte_if.in_valid = 1'b0;
        e = edge_cnt;
        if (n == NPIX) begin
            foreach (tmp[k]) exp_pix.push_back(tmp[k]);
            exp_start.push_back(e + 1);
        end
    endtask

    // Waits until the last pixel, then returns a result delay cycles into WAIT_RESULT.
    task automatic wait_result(input int e, input int delay, input logic [RW-1:0] cls);
        int p0;
        while (edge_cnt < e + NPIX) @(negedge clk);
        check("busy_in_wait", 64'(busy), 64'(1));
        repeat (delay) @(negedge clk);
        p0 = pulse_count;
        output_result = {1'b1, cls};
        @(negedge clk);
        output_result = '0;
        check("class_valid_pulse", 64'(class_valid), 64'(1));
        check("class_out", 64'(class_out), 64'(cls));
        check("in_ready_after_result", 64'(byte_if.in_ready), 64'(1));
        check("busy_after_result", 64'(busy), 64'(0));
        @(negedge clk);
        check("class_valid_width", 64'(class_valid), 64'(0));
        check("class_pulse_count", 64'(pulse_count - p0), 64'(1));
    endtask

    initial begin
        int e, p0, en0;
        rst = 1'b1;
        byte_if.in_valid = 1'b0;
        byte_if.in_data  = '0;
        output_result    = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(byte_if.in_ready), 64'(0));
        check("rst_enable", 64'(input_enable), 64'(0));
        check("rst_index", 64'(input_index), 64'(0));
        check("rst_value", 64'(input_value), 64'(0));
        check("rst_class_out", 64'(class_out), 64'(0));
        check("rst_class_valid", 64'(class_valid), 64'(0));
        check("rst_timeout_err", 64'(timeout_err), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        mon_on = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 64'(byte_if.in_ready), 64'(1));

        // Basic frame with literal pins on the first and last pixel.
        send_frame(0, NPIX, 1'b0, e);
        check("in_ready_after_last_byte", 64'(byte_if.in_ready), 64'(0));
        check("busy_stream", 64'(busy), 64'(1));
        check("no_enable_before_read", 64'(input_enable), 64'(0));
        @(negedge clk);
        check("first_enable", 64'(input_enable), 64'(1));
        check("first_index", 64'(input_index), 64'(0));
        check("first_value", 64'(input_value), 64'(8'h00));
        while (edge_cnt < e + NPIX) @(negedge clk);
        check("last_index", 64'(input_index), 64'(10'd1023));
        check("last_value", 64'(input_value), 64'(8'hFF));
        wait_result(e, 50, RW'(7));

        // Result-valid in FILL is ignored.
        output_result = {1'b1, RW'(99)};
        @(negedge clk);
        output_result = '0;
        check("fill_result_ignored_valid", 64'(class_valid), 64'(0));
        check("fill_result_ignored_class", 64'(class_out), 64'(7));

        // Ten back-to-back frames, class n for frame n.
        p0 = pulse_count;
        en0 = en_count;
        for (int n = 0; n < 10; n++) begin
            send_frame(10 + n, NPIX, 1'b0, e);
            if (n == 0) begin
                while (edge_cnt < e + 500) @(negedge clk);
                output_result = {1'b1, RW'(77)};
                @(negedge clk);
                output_result = '0;
                check("stream_result_ignored_valid", 64'(class_valid), 64'(0));
                check("stream_result_ignored_class", 64'(class_out), 64'(7));
            end
            wait_result(e, 10 + n, RW'(n));
        end
        check("ten_frame_pulses", 64'(pulse_count - p0), 64'(10));
        check("ten_frame_enables", 64'(en_count - en0), 64'(10 * NPIX));

        // Bursty fill; result lands on the last allowed WAIT cycle and beats the timeout.
        send_frame(0, NPIX, 1'b1, e);
        wait_result(e, TB_TOUT - 1, RW'(3));
        check("tie_no_timeout", 64'(timeout_err), 64'(0));

        // Timeout with no response.
        send_frame(1, NPIX, 1'b0, e);
        while (edge_cnt < e + NPIX) @(negedge clk);
        p0 = pulse_count;
        repeat (TB_TOUT - 1) @(negedge clk);
        check("timeout_not_yet", 64'(timeout_err), 64'(0));
        check("timeout_not_yet_ready", 64'(byte_if.in_ready), 64'(0));
        @(negedge clk);
        check("timeout_err_set", 64'(timeout_err), 64'(1));
        check("timeout_back_to_fill", 64'(byte_if.in_ready), 64'(1));
        check("timeout_busy", 64'(busy), 64'(0));
        check("timeout_class_kept", 64'(class_out), 64'(3));
        repeat (3) @(negedge clk);
        check("timeout_no_pulse", 64'(pulse_count - p0), 64'(0));
        check("timeout_sticky", 64'(timeout_err), 64'(1));
        send_frame(2, NPIX, 1'b0, e);
        wait_result(e, 20, RW'(5));
        check("timeout_sticky_after_frame", 64'(timeout_err), 64'(1));

        // Reset after 500 bytes; only the following full frame is streamed.
        send_frame(5, 500, 1'b0, e);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midrst_in_ready", 64'(byte_if.in_ready), 64'(0));
        check("midrst_timeout_err", 64'(timeout_err), 64'(0));
        check("midrst_class_out", 64'(class_out), 64'(0));
        check("midrst_value", 64'(input_value), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_after", 64'(byte_if.in_ready), 64'(1));
        en0 = en_count;
        send_frame(6, NPIX, 1'b0, e);
        while (edge_cnt < e + NPIX + 2) @(negedge clk);
        check("midrst_enable_count", 64'(en_count - en0), 64'(NPIX));
        check("midrst_no_timeout", 64'(timeout_err), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation watchdog expired");
    end

endmodule
